// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-side responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mem_state_t;

  localparam int LAT_CNT_WIDTH = 4;

  // The caller truncates the result to its own index width.
  function automatic logic [29:0] word_index(input logic [31:0] addr);
    return addr[31:2];
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, registered read data, write-first.
module mem_array #(
  parameter int IDX_WIDTH  = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [IDX_WIDTH-1:0]  idx_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] ram [2**IDX_WIDTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      ram[idx_i] <= wdata_i;
      rdata_o    <= wdata_i;
    end else begin
      rdata_o <= ram[idx_i];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency word RAM responder for the cache memory port.
// Define MEM_STATS_EN to add saturating read/write access counters.
module mem_responder
  import mem_pkg::*;
#(
  parameter int WORD_ADDR_WIDTH = 10,
  parameter int LATENCY         = 4,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  write_en_i,
  input  logic [31:0]           addr_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] read_data_o,
  output logic                  busy_o
`ifdef MEM_STATS_EN
  ,
  output logic [31:0]           rd_count_o,
  output logic [31:0]           wr_count_o
`endif
);

  mem_state_t                 state;
  logic [LAT_CNT_WIDTH-1:0]   cnt;
  logic [WORD_ADDR_WIDTH-1:0] lat_idx;
  logic                       lat_we;
  logic [DATA_WIDTH-1:0]      lat_wdata;

  logic                       accept;
  logic                       finish;
  logic                       done_we;
  logic                       ram_we;
  logic [WORD_ADDR_WIDTH-1:0] ram_idx;
  logic [DATA_WIDTH-1:0]      ram_wdata;
  logic [DATA_WIDTH-1:0]      ram_rdata;

  // The RAM is accessed on the edge that enters DONE; with LATENCY = 1 that
  // is the accepting edge itself, so the request inputs bypass the latches.
  always_comb begin
    accept    = req_i && (state == IDLE || state == DONE);
    finish    = (accept && LATENCY == 1) ||
                (state == BUSY && cnt == LAT_CNT_WIDTH'(1));
    done_we   = accept ? write_en_i : lat_we;
    ram_idx   = accept ? WORD_ADDR_WIDTH'(word_index(addr_i)) : lat_idx;
    ram_wdata = accept ? write_data_i : lat_wdata;
    ram_we    = rst_i && finish && done_we;
  end

  mem_array #(
    .IDX_WIDTH (WORD_ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .clk_i  (clk_i),
    .we_i   (ram_we),
    .idx_i  (ram_idx),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  // ready_o and read_data_o trail DONE by one edge so they leave together
  // with the RAM's registered read (or write-first echo) data.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_idx     <= '0;
      lat_we      <= 1'b0;
      lat_wdata   <= '0;
      ready_o     <= 1'b0;
      busy_o      <= 1'b0;
      read_data_o <= '0;
    end else begin
      ready_o <= (state == DONE);
      if (state == DONE) begin
        read_data_o <= ram_rdata;
      end
      case (state)
        IDLE, DONE: begin
          if (req_i) begin
            lat_idx   <= WORD_ADDR_WIDTH'(word_index(addr_i));
            lat_we    <= write_en_i;
            lat_wdata <= write_data_i;
            if (LATENCY == 1) begin
              state  <= DONE;
              busy_o <= 1'b0;
            end else begin
              cnt    <= LAT_CNT_WIDTH'(LATENCY - 1);
              state  <= BUSY;
              busy_o <= 1'b1;
            end
          end else begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        BUSY: begin
          cnt <= cnt - LAT_CNT_WIDTH'(1);
          if (cnt == LAT_CNT_WIDTH'(1)) begin
            state  <= DONE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_STATS_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rd_count_o <= '0;
      wr_count_o <= '0;
    end else if (finish) begin
      if (done_we) begin
        if (wr_count_o != 32'hFFFF_FFFF) wr_count_o <= wr_count_o + 32'd1;
      end else begin
        if (rd_count_o != 32'hFFFF_FFFF) rd_count_o <= rd_count_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder at LATENCY 4 and LATENCY 1.
// Build with MEM_STATS_EN defined to also check the access counters.
module tb_mem_responder;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        q4[$];
  exp_t        q1[$];

  logic        req4 = 1'b0, we4 = 1'b0;
  logic [31:0] addr4 = '0, wdata4 = '0;
  logic        ready4, busy4;
  logic [31:0] rdata4;
  logic        req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr1 = '0, wdata1 = '0;
  logic        ready1, busy1;
  logic [31:0] rdata1;
`ifdef MEM_STATS_EN
  logic [31:0] rdc4, wrc4, rdc1, wrc1;
`endif

  mem_responder #(.WORD_ADDR_WIDTH(10), .LATENCY(4), .DATA_WIDTH(32)) dut4 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req4), .write_en_i(we4),
    .addr_i(addr4), .write_data_i(wdata4), .ready_o(ready4),
    .read_data_o(rdata4), .busy_o(busy4)
`ifdef MEM_STATS_EN
    , .rd_count_o(rdc4), .wr_count_o(wrc4)
`endif
  );

  mem_responder #(.WORD_ADDR_WIDTH(10), .LATENCY(1), .DATA_WIDTH(32)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req1), .write_en_i(we1),
    .addr_i(addr1), .write_data_i(wdata1), .ready_o(ready1),
    .read_data_o(rdata1), .busy_o(busy1)
`ifdef MEM_STATS_EN
    , .rd_count_o(rdc1), .wr_count_o(wrc1)
`endif
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard for the LATENCY 4 instance: every ready pulse pops one entry.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (ready4) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_ready4 cycle %0d: ready=1, required ready=0", cyc);
      end else begin
        e = q4.pop_front();
        if (rdata4 !== e.data) begin
          errors++;
          $display("[TB] FAIL read_data4 cycle %0d: got %h, expected %h", cyc, rdata4, e.data);
        end
        checks++;
        if (cyc != e.due) begin
          errors++;
          $display("[TB] FAIL ready4_timing: ready at cycle %0d, expected cycle %0d", cyc, e.due);
        end
      end
    end else if (q4.size() > 0 && cyc > q4[0].due) begin
      checks++;
      errors++;
      $display("[TB] FAIL missed_ready4: no ready by cycle %0d, expected at %0d", cyc, q4[0].due);
      void'(q4.pop_front());
    end
  end

  // Scoreboard for the LATENCY 1 instance.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (ready1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_ready1 cycle %0d: ready=1, required ready=0", cyc);
      end else begin
        e = q1.pop_front();
        if (rdata1 !== e.data) begin
          errors++;
          $display("[TB] FAIL read_data1 cycle %0d: got %h, expected %h", cyc, rdata1, e.data);
        end
        checks++;
        if (cyc != e.due) begin
          errors++;
          $display("[TB] FAIL ready1_timing: ready at cycle %0d, expected cycle %0d", cyc, e.due);
        end
      end
    end else if (q1.size() > 0 && cyc > q1[0].due) begin
      checks++;
      errors++;
      $display("[TB] FAIL missed_ready1: no ready by cycle %0d, expected at %0d", cyc, q1[0].due);
      void'(q1.pop_front());
    end
  end

  task automatic issue4(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] expd);
    exp_t e;
    @(negedge clk);
    req4 = 1'b1; we4 = we; addr4 = addr; wdata4 = data;
    e.data = expd;
    e.due  = cyc + 1 + 4;
    q4.push_back(e);
    @(negedge clk);
    req4 = 1'b0; we4 = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && (q4.size() > 0 || q1.size() > 0); i++) @(negedge clk);
    checks++;
    if (q4.size() > 0 || q1.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: %0d/%0d entries left, required 0", q4.size(), q1.size());
      q4.delete();
      q1.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks += 3;
      if (ready4 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_ready: got %b, expected 0", ready4);
      end
      if (busy4 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_busy: got %b, expected 0", busy4);
      end
      if (rdata4 !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_read_data: got %h, expected 0", rdata4);
      end
    end
  endtask

  task automatic test_write_read();
    issue4(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    wait_drain();
    issue4(1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF);
    wait_drain();
    checks++;
    if (rdata4 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("[TB] FAIL read_data_hold: got %h, expected deadbeef", rdata4);
    end
  endtask

  task automatic test_alias();
    issue4(1'b1, 32'h0000_0004, 32'h1234_5678, 32'h1234_5678);
    wait_drain();
    issue4(1'b0, 32'h0000_1004, 32'h0, 32'h1234_5678);
    wait_drain();
    issue4(1'b0, 32'h0000_0007, 32'h0, 32'h1234_5678);
    wait_drain();
  endtask

  task automatic test_busy_ignore();
    exp_t e;
    issue4(1'b1, 32'h0000_0200, 32'hB0B0_B0B0, 32'hB0B0_B0B0);
    wait_drain();
    @(negedge clk);
    req4 = 1'b1; we4 = 1'b1; addr4 = 32'h0000_0100; wdata4 = 32'h2222_2222;
    e.data = 32'h2222_2222;
    e.due  = cyc + 1 + 4;
    q4.push_back(e);
    @(negedge clk);
    addr4 = 32'h0000_0200; wdata4 = 32'h3333_3333;
    checks++;
    if (busy4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_flag: got %b, expected 1", busy4);
    end
    @(negedge clk);
    req4 = 1'b0; we4 = 1'b0;
    wait_drain();
    issue4(1'b0, 32'h0000_0200, 32'h0, 32'hB0B0_B0B0);
    wait_drain();
    issue4(1'b0, 32'h0000_0100, 32'h0, 32'h2222_2222);
    wait_drain();
  endtask

  task automatic test_reset_mid();
    issue4(1'b1, 32'h0000_0080, 32'h1122_3344, 32'h1122_3344);
    wait_drain();
    @(negedge clk);
    req4 = 1'b1; we4 = 1'b1; addr4 = 32'h0000_0080; wdata4 = 32'hCAFE_F00D;
    @(negedge clk);
    req4 = 1'b0; we4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (ready4 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL abandoned_ready: got %b, expected 0", ready4);
      end
    end
    issue4(1'b0, 32'h0000_0080, 32'h0, 32'h1122_3344);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h0000_0300; wdata1 = 32'hA5A5_A5A5;
    e.data = 32'hA5A5_A5A5;
    e.due  = cyc + 2;
    q1.push_back(e);
    @(negedge clk);
    we1 = 1'b0; wdata1 = 32'h0;
    e.data = 32'hA5A5_A5A5;
    e.due  = cyc + 2;
    q1.push_back(e);
    @(negedge clk);
    req1 = 1'b0;
    wait_drain();
`ifdef MEM_STATS_EN
    checks += 2;
    if (wrc1 !== 32'd1) begin
      errors++;
      $display("[TB] FAIL wr_count: got %0d, expected 1", wrc1);
    end
    if (rdc1 !== 32'd1) begin
      errors++;
      $display("[TB] FAIL rd_count: got %0d, expected 1", rdc1);
    end
`endif
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_write_read();
    test_alias();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

endmodule
